// File: rtl/loop_replay_unit.sv
// loop_replay_unit
//   Reader/issue side of the loop micro-op buffer. The loop-capture FSM
//   writes the loop body through the write port while the unit is idle. A
//   loop_valid pulse then starts replay: the body is streamed to decode, one
//   instruction per non-stalled cycle, until a mispredict ends replay with a
//   one-cycle flush.
//
// Handshake: out_instr/out_pc are meaningful only while out_valid=1. A beat
//   is consumed on every cycle with out_valid=1 and stall=0. With stall=1 the
//   same beat is held unchanged until a cycle with stall=0.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   wr_en, wr_instr      append one instruction (IDLE only)
//   wr_clear             empty the buffer and clear wr_overflow (IDLE only)
//   loop_valid           start replay of loop_len entries at loop_start_pc
//   loop_start_pc        PC of the first loop instruction
//   loop_len             loop length, 1..2**AW
//   stall                downstream cannot take the current beat
//   mispredict           leave replay (PRIME/REPLAY only)
//   replay_active        high in PRIME and REPLAY
//   out_valid            out_instr/out_pc valid
//   out_instr, out_pc    replayed instruction and its PC
//   flush                one-cycle pulse after a mispredict exit
//   wr_count             number of buffered entries
//   wr_overflow          sticky: a write arrived while the buffer was full
//   iter_count           completed loop iterations, saturating
module loop_replay_unit #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_instr,
  input  logic          wr_clear,
  input  logic          loop_valid,
  input  logic [31:0]   loop_start_pc,
  input  logic [AW:0]   loop_len,
  input  logic          stall,
  input  logic          mispredict,
  output logic          replay_active,
  output logic          out_valid,
  output logic [DW-1:0] out_instr,
  output logic [31:0]   out_pc,
  output logic          flush,
  output logic [AW:0]   wr_count,
  output logic          wr_overflow,
  output logic [15:0]   iter_count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_REPLAY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          mem_we;

  logic [AW:0]   wr_count_q, wr_count_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [31:0]   start_pc_q, start_pc_d;
  logic [31:0]   pc_q, pc_d;
  logic [15:0]   iter_q, iter_d;
  logic          flush_q, flush_d;

  logic          last_idx;
  logic [AW-1:0] next_idx;

  // wr_count doubles as the write pointer: entries are appended in order and
  // only ever cleared as a whole.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_count_q[AW-1:0]] <= wr_instr;
  end

  // Read register only moves on rd_en, which is what holds out_instr during
  // a stall without any extra muxing.
  always_ff @(posedge clk) begin
    if (reset)      rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_count_q <= '0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      start_pc_q <= '0;
      pc_q       <= '0;
      iter_q     <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      start_pc_q <= start_pc_d;
      pc_q       <= pc_d;
      iter_q     <= iter_d;
      flush_q    <= flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    len_d      = len_q;
    start_pc_d = start_pc_q;
    pc_d       = pc_q;
    iter_d     = iter_q;
    flush_d    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    mem_we     = 1'b0;
    last_idx   = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    next_idx   = last_idx ? '0 : idx_q + AW'(1);

    case (state_q)
      S_IDLE: begin
        if (wr_clear) begin
          wr_count_d = '0;
          ovf_d      = 1'b0;
        end else if (wr_en) begin
          if (wr_count_q == DEPTH) begin
            ovf_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + (AW+1)'(1);
          end
        end
        if (loop_valid && !mispredict && (loop_len != '0) &&
            (loop_len <= wr_count_q)) begin
          start_pc_d = loop_start_pc;
          len_d      = loop_len;
          idx_d      = '0;
          iter_d     = '0;
          state_d    = S_PRIME;
        end
      end

      S_PRIME: begin
        if (mispredict) begin
          state_d    = S_IDLE;
          flush_d    = 1'b1;
          wr_count_d = '0;
        end else begin
          rd_en   = 1'b1;
          rd_addr = '0;
          pc_d    = start_pc_q;
          state_d = S_REPLAY;
        end
      end

      S_REPLAY: begin
        if (mispredict) begin
          state_d    = S_IDLE;
          flush_d    = 1'b1;
          wr_count_d = '0;
        end else if (!stall) begin
          // Fetch the following entry in the same cycle the current one is
          // consumed, so the wrap back to entry 0 costs no bubble.
          rd_en   = 1'b1;
          rd_addr = next_idx;
          idx_d   = next_idx;
          pc_d    = start_pc_q + {{(30-AW){1'b0}}, next_idx, 2'b00};
          if (last_idx && (iter_q != 16'hFFFF)) iter_d = iter_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign replay_active = (state_q != S_IDLE);
  assign out_valid     = (state_q == S_REPLAY);
  assign out_instr     = rd_data_q;
  assign out_pc        = pc_q;
  assign flush         = flush_q;
  assign wr_count      = wr_count_q;
  assign wr_overflow   = ovf_q;
  assign iter_count    = iter_q;

endmodule

// File: tb/tb_loop_replay_unit.sv
module tb_loop_replay_unit;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_instr;
  logic          wr_clear;
  logic          loop_valid;
  logic [31:0]   loop_start_pc;
  logic [AW:0]   loop_len;
  logic          stall;
  logic          mispredict;
  logic          replay_active;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [31:0]   out_pc;
  logic          flush;
  logic [AW:0]   wr_count;
  logic          wr_overflow;
  logic [15:0]   iter_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];

  loop_replay_unit #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_instr      (wr_instr),
    .wr_clear      (wr_clear),
    .loop_valid    (loop_valid),
    .loop_start_pc (loop_start_pc),
    .loop_len      (loop_len),
    .stall         (stall),
    .mispredict    (mispredict),
    .replay_active (replay_active),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .flush         (flush),
    .wr_count      (wr_count),
    .wr_overflow   (wr_overflow),
    .iter_count    (iter_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [31:0] data);
    wr_en    = 1'b1;
    wr_instr = data;
    step();
    wr_en    = 1'b0;
  endtask

  task automatic start_loop(input logic [31:0] pc, input logic [AW:0] len);
    loop_valid    = 1'b1;
    loop_start_pc = pc;
    loop_len      = len;
    step();
    loop_valid    = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_valid"},  {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_active"}, {31'd0, replay_active}, 32'd0);
    check_eq({tag, "_flush"},  {31'd0, flush}, 32'd0);
    check_eq({tag, "_instr"},  out_instr, 32'd0);
    check_eq({tag, "_pc"},     out_pc, 32'd0);
    check_eq({tag, "_wcnt"},   {25'd0, wr_count}, 32'd0);
    check_eq({tag, "_ovf"},    {31'd0, wr_overflow}, 32'd0);
    check_eq({tag, "_iter"},   {16'd0, iter_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_instr;
    reset = 1'b1; wr_en = 1'b0; wr_instr = '0; wr_clear = 1'b0;
    loop_valid = 1'b0; loop_start_pc = '0; loop_len = '0;
    stall = 1'b0; mispredict = 1'b0;
    #1;
    step();
    step();
    reset = 1'b0;
    check_idle_zero("rst");

    // Basic replay of a 4-entry loop
    do_write(32'hA0); do_write(32'hA1); do_write(32'hA2); do_write(32'hA3);
    check_eq("wcnt4", {25'd0, wr_count}, 32'd4);
    start_loop(32'h100, 7'd4);
    check_eq("prime_active", {31'd0, replay_active}, 32'd1);
    check_eq("prime_valid", {31'd0, out_valid}, 32'd0);
    step();
    for (int k = 0; k < 10; k++) exp_q.push_back(32'hA0 + (k % 4));
    for (int k = 0; k < 10; k++) begin
      exp_instr = exp_q.pop_front();
      check_eq("r4_valid", {31'd0, out_valid}, 32'd1);
      check_eq("r4_instr", out_instr, exp_instr);
      check_eq("r4_pc", out_pc, 32'h100 + 32'(4 * (k % 4)));
      check_eq("r4_iter", {16'd0, iter_count}, 32'(k / 4));
      // writes and a second loop_valid while replaying must be ignored
      wr_en      = (k == 5);
      wr_instr   = 32'hEE;
      loop_valid = (k == 6);
      loop_len   = 7'd1;
      step();
    end
    wr_en = 1'b0; loop_valid = 1'b0;
    check_eq("r4_wcnt_hold", {25'd0, wr_count}, 32'd4);

    // Stall while A2 is presented: held for 3 stalled cycles plus one
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq("st_instr", out_instr, 32'hA2);
      check_eq("st_pc", out_pc, 32'h108);
      check_eq("st_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    stall = 1'b0;
    check_eq("st_rel_instr", out_instr, 32'hA2);
    check_eq("st_rel_pc", out_pc, 32'h108);
    step();
    check_eq("st_next_instr", out_instr, 32'hA3);
    check_eq("st_next_pc", out_pc, 32'h10C);
    step();
    check_eq("st_wrap_instr", out_instr, 32'hA0);
    check_eq("st_wrap_iter", {16'd0, iter_count}, 32'd3);

    // Mispredict while stalled
    stall = 1'b1; mispredict = 1'b1;
    step();
    stall = 1'b0; mispredict = 1'b0;
    check_eq("mp_flush", {31'd0, flush}, 32'd1);
    check_eq("mp_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mp_active", {31'd0, replay_active}, 32'd0);
    check_eq("mp_wcnt", {25'd0, wr_count}, 32'd0);
    check_eq("mp_iter_hold", {16'd0, iter_count}, 32'd3);
    mispredict = 1'b1;  // no effect in IDLE
    step();
    mispredict = 1'b0;
    check_eq("mp_flush_once", {31'd0, flush}, 32'd0);

    // len=1 loop with iteration counter saturation
    do_write(32'hBB);
    start_loop(32'h200, 7'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      check_eq("l1_instr", out_instr, 32'hBB);
      check_eq("l1_pc", out_pc, 32'h200);
      check_eq("l1_iter", {16'd0, iter_count}, 32'(k));
      step();
    end
    repeat (65531) step();
    check_eq("l1_iter_fffe", {16'd0, iter_count}, 32'hFFFE);
    step();
    check_eq("l1_iter_ffff", {16'd0, iter_count}, 32'hFFFF);
    step();
    check_eq("l1_iter_sat", {16'd0, iter_count}, 32'hFFFF);
    check_eq("l1_instr_end", out_instr, 32'hBB);
    check_eq("l1_pc_end", out_pc, 32'h200);
    mispredict = 1'b1;
    step();
    mispredict = 1'b0;
    check_eq("l1_flush", {31'd0, flush}, 32'd1);

    // Overflow, clear, and rejected loop_valid
    for (int k = 0; k < 65; k++) do_write(32'h1000 + 32'(k));
    check_eq("of_wcnt", {25'd0, wr_count}, 32'd64);
    check_eq("of_ovf", {31'd0, wr_overflow}, 32'd1);
    wr_clear = 1'b1; wr_en = 1'b1;
    step();
    wr_clear = 1'b0; wr_en = 1'b0;
    check_eq("clr_wcnt", {25'd0, wr_count}, 32'd0);
    check_eq("clr_ovf", {31'd0, wr_overflow}, 32'd0);
    do_write(32'hC0); do_write(32'hC1); do_write(32'hC2);
    start_loop(32'h400, 7'd5);
    check_eq("rej_len5", {31'd0, replay_active}, 32'd0);
    start_loop(32'h400, 7'd0);
    check_eq("rej_len0", {31'd0, replay_active}, 32'd0);
    mispredict = 1'b1;
    start_loop(32'h400, 7'd3);
    mispredict = 1'b0;
    check_eq("rej_mp", {31'd0, replay_active}, 32'd0);

    // PC wraps modulo 2**32; then reset mid-replay
    start_loop(32'hFFFF_FFF8, 7'd3);
    step();
    check_eq("pw0_instr", out_instr, 32'hC0);
    check_eq("pw0_pc", out_pc, 32'hFFFF_FFF8);
    step();
    check_eq("pw1_pc", out_pc, 32'hFFFF_FFFC);
    step();
    check_eq("pw2_instr", out_instr, 32'hC2);
    check_eq("pw2_pc", out_pc, 32'h0000_0000);
    reset = 1'b1; mispredict = 1'b1;
    step();
    reset = 1'b0; mispredict = 1'b0;
    check_idle_zero("mid_rst");
    step();
    check_eq("mid_rst_flush2", {31'd0, flush}, 32'd0);

    // Fresh capture after reset
    do_write(32'hD0); do_write(32'hD1);
    start_loop(32'h300, 7'd2);
    check_eq("re_prime", {31'd0, replay_active}, 32'd1);
    step();
    check_eq("re0_instr", out_instr, 32'hD0);
    check_eq("re0_pc", out_pc, 32'h300);
    step();
    check_eq("re1_instr", out_instr, 32'hD1);
    check_eq("re1_pc", out_pc, 32'h304);
    step();
    check_eq("re2_instr", out_instr, 32'hD0);
    check_eq("re2_iter", {16'd0, iter_count}, 32'd1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/loop_replay_unit.md
Name: loop_replay_unit

Overview:
- Reader/issue side of the loop micro-op buffer: holds the instructions written by the loop-capture FSM and replays them into decode while fetch is blocked.
- Sits between the instruction buffer and the IF/ID register, alongside the loop-capture FSM.
- Streams the loop body with a valid/stall handshake and tags each instruction with its PC.
- Exits replay on mispredict and emits a one-cycle flush.

Parameters:
- AW, 6, buffer address width; depth = 2**AW entries (64).
- DW, 32, instruction width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write wr_instr at the write pointer, then increment the pointer.
- wr_instr  in  DW  captured instruction.
- wr_clear  in  1  zero the write pointer and wr_count.
- loop_valid  in  1  pulse: capture complete, start replay.
- loop_start_pc  in  32  PC of the first loop instruction.
- loop_len  in  AW+1  loop length in instructions (1..2**AW).
- stall  in  1  downstream cannot accept this cycle.
- mispredict  in  1  loop-exit branch resolved; leave replay.
- replay_active  out  1  high in PRIME and REPLAY (blocks fetch).
- out_valid  out  1  out_instr/out_pc are valid.
- out_instr  out  DW  replayed instruction.
- out_pc  out  32  PC of out_instr.
- flush  out  1  one-cycle pulse on replay exit.
- wr_count  out  AW+1  entries written.
- wr_overflow  out  1  sticky: a write was attempted while full.
- iter_count  out  16  completed loop iterations, saturating.

Behaviour:
- Reset: state=IDLE. All outputs are 0. Write pointer, read index and wr_count are 0. wr_overflow is cleared. Reset overrides every other input in the same cycle, including mid-replay; no flush is emitted on reset.
- Buffer: 2**AW x DW RAM.
  - Synchronous write.
  - Synchronous read, 1-cycle latency. The read output register updates only when rd_en=1.
- Write side, active in IDLE only:
  - wr_clear has priority over wr_en.
  - When wr_count==2**AW, a write is dropped and sets wr_overflow. wr_overflow clears only on reset or wr_clear.
  - In PRIME and REPLAY, writes are ignored.
- IDLE state:
  - loop_valid is accepted when 1<=loop_len<=wr_count and mispredict=0. Otherwise it is ignored and the state stays IDLE.
  - On accept, latch start_pc and len; idx<=0; iter_count<=0; go to PRIME.
- PRIME state:
  - Assert rd_en with addr 0; out_pc<=start_pc; go to REPLAY.
  - replay_active=1, out_valid=0.
- REPLAY state:
  - out_valid=1, out_instr=RAM output.
  - If stall=1: hold idx, out_instr and out_pc; rd_en=0.
  - If stall=0 (advance):
    - next_idx = (idx==len-1) ? 0 : idx+1.
    - rd_en=1 with addr next_idx; idx<=next_idx.
    - out_pc<=start_pc + (next_idx<<2), computed as 32-bit modulo arithmetic.
  - On advance with idx==len-1, iter_count increments, saturating at 16'hFFFF.
  - len=1 replays the same instruction every non-stalled cycle, and iter_count increments every advance.
- Mispredict in PRIME or REPLAY (priority over stall):
  - Next cycle: flush=1 for exactly one cycle, state=IDLE, out_valid=0, replay_active=0.
  - Write pointer and wr_count are cleared.
  - iter_count holds its value until the next accepted loop_valid.
- In IDLE, mispredict has no effect.
- loop_valid received in PRIME or REPLAY is ignored.
- Latency: loop_valid accepted at cycle T:
  - replay_active=1 at T+1.
  - out_valid=1 at T+2, carrying entry 0 with out_pc=start_pc.
  - One new instruction per non-stalled cycle thereafter.
- Throughput: 1 instruction/cycle with no bubbles at the loop wrap.

Test Plan:
- Write 0xA0,0xA1,0xA2,0xA3; loop_valid with len=4, start=0x100 at cycle T, stall=0 -> from T+2 out_instr A0,A1,A2,A3,A0,... with out_pc 0x100,0x104,0x108,0x10C,0x100,...; iter_count=1 at the first wrap, 2 at the second.
- Same setup, stall high for 3 cycles while out_instr=A2 -> A2/0x108 held for the stall cycles plus one, then A3 follows; no instruction skipped or duplicated.
- Mispredict during REPLAY while stall=1 -> next cycle flush=1 (one cycle), out_valid=0, replay_active=0, wr_count=0.
- len=1, one write 0xBB, start=0x200 -> out_instr 0xBB and out_pc 0x200 every cycle; iter_count increments each cycle and saturates at 0xFFFF.
- 65 writes into the 64-entry buffer -> wr_count=64, wr_overflow=1; loop_valid with len=5 and only 3 writes -> ignored, replay_active stays 0.
- reset=1 asserted mid-REPLAY -> next cycle all outputs 0, state IDLE, no flush pulse; a new capture and loop_valid afterwards replays correctly.
